// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: oversamples SCLK/MOSI/SS_n in clk_clk, deserialises MOSI, serialises a 1-deep tx buffer on MISO.
// Latency: pin edge to action 3 clk_clk cycles; rx_valid one cycle after the detected last SCLK rise.
// Backpressure: tx side valid/ready into a single-word buffer; rx side has none (rx_data is simply overwritten).
//
// Ports:
//   clk_clk, reset_reset_n      : system clock, synchronous active-low reset
//   spi_SCLK, spi_MOSI, spi_SS_n: SPI pins from the master (asynchronous)
//   spi_MISO, miso_oe           : serial data to the master and its pad output enable
//   tx_data/tx_valid/tx_ready   : word offered for transmission into the one-deep buffer
//   rx_data/rx_valid            : last complete received word, pulse on update
//   underrun                    : pulse when a word start found the tx buffer empty
//   busy                        : responder is selected (synchronised SS_n low)
module spi_slave_resp #(
  parameter int unsigned       DATA_W     = 8,
  parameter logic [DATA_W-1:0] TX_DEFAULT = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_SS_n,
  output logic              spi_MISO,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned     CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  // Pin synchronisers; stage 3 of SCLK/SS_n is the "previous" value for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                reload_q, reload_d;
  // Only the low DATA_W-1 bits need storing: the newest bit comes straight from the synchroniser.
  logic [DATA_W-2:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  // Bits still to be sent; the current bit already sits in miso_q.
  logic [DATA_W-2:0]   tx_sh_q, tx_sh_d;
  logic                miso_q, miso_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                full_q, full_d;
  logic                underrun_q, underrun_d;

  logic                sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                load;
  logic [DATA_W-1:0]   load_word;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    buf_d      = buf_q;
    full_d     = full_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    load_word  = TX_DEFAULT;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        reload_d = 1'b0;
        if (ss_fall) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          // Partial word dropped; the next select starts aligned at the MSB.
          state_d  = IDLE;
          cnt_d    = '0;
          reload_d = 1'b0;
        end else if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[DATA_W-3:0], mosi_s2_q};
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_sh_q, mosi_s2_q};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            reload_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            // Falling edge after a word's last sample: next word's MSB goes out now.
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            miso_d  = tx_sh_q[DATA_W-2];
            tx_sh_d = {tx_sh_q[DATA_W-3:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load evaluates the buffer before this cycle's write, so a same-cycle offer misses it.
    if (load) begin
      if (full_q) begin
        load_word = buf_q;
        full_d    = 1'b0;
      end else begin
        load_word  = TX_DEFAULT;
        underrun_d = 1'b1;
      end
      miso_d  = load_word[DATA_W-1];
      tx_sh_d = load_word[DATA_W-2:0];
    end

    if (tx_valid && !full_q) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_s3_q    <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sclk_s1_q  <= spi_SCLK;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      ss_s1_q    <= spi_SS_n;
      ss_s2_q    <= ss_s1_q;
      ss_s3_q    <= ss_s2_q;
      mosi_s1_q  <= spi_MOSI;
      mosi_s2_q  <= mosi_s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  assign spi_MISO = miso_q;
  assign miso_oe  = (state_q == ACTIVE);
  assign busy     = (state_q == ACTIVE);
  assign tx_ready = ~full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Bench for spi_slave_resp: bit-banged mode-0 master at SCLK = clk/8.
// Received words are scoreboarded through a queue; MISO words and underrun counts are checked per transaction.
// Inputs driven on the falling clock edge, outputs sampled there too.
module tb_spi_slave_resp;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       spi_SCLK, spi_MOSI, spi_SS_n;
  logic       spi_MISO, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, underrun, busy;

  int         tests = 0;
  int         fails = 0;
  int         und_cnt = 0;
  bit         idle_watch = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] mosi_w[4];
  logic [7:0] miso_w[4];

  always #5 clk_clk = ~clk_clk;

  spi_slave_resp #(.DATA_W(8), .TX_DEFAULT(8'h00)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi_SCLK      (spi_SCLK),
    .spi_MOSI      (spi_MOSI),
    .spi_SS_n      (spi_SS_n),
    .spi_MISO      (spi_MISO),
    .miso_oe       (miso_oe),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .underrun      (underrun),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Output monitor: rx scoreboard, underrun pulse counter, idle output-enable watch.
  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1) begin
      if (underrun === 1'b1) und_cnt++;
      if (rx_valid === 1'b1) begin
        if (rx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got rx_valid with 0x%0h, expected no word", rx_data);
        end else begin
          logic [7:0] e;
          e = rx_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e));
        end
      end
      if (idle_watch) check("idle_miso_oe", 32'(miso_oe), 32'h0);
    end
  end

  task automatic push_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk_clk);
      t++;
    end
    check("push_tx_ready", 32'(tx_ready), 32'h1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_clk);
    tx_valid = 1'b0;
  endtask

  // One select period: nwords words from mosi_w, MISO captured into miso_w at each SCLK rise.
  // abort_bits != 0 stops after that many bits of the first word. collide offers coll_dat in the load cycle.
  task automatic xfer(input int nwords, input int abort_bits, input bit collide, input logic [7:0] coll_dat);
    int sent;
    sent = 0;
    spi_SS_n = 1'b0;
    if (collide) begin
      clk_n(2);
      tx_data  = coll_dat;
      tx_valid = 1'b1;
      clk_n(1);
      tx_valid = 1'b0;
      check("coll_underrun_pulse", 32'(underrun), 32'h1);
      check("coll_tx_ready", 32'(tx_ready), 32'h0);
      clk_n(2);
    end else begin
      clk_n(5);
    end
    for (int w = 0; w < nwords; w++) begin
      if (abort_bits == 0) rx_q.push_back(mosi_w[w]);
      for (int b = 7; b >= 0; b--) begin
        if (abort_bits != 0 && sent == abort_bits) break;
        spi_MOSI = mosi_w[w][b];
        clk_n(4);
        spi_SCLK = 1'b1;
        miso_w[w][b] = spi_MISO;
        clk_n(4);
        spi_SCLK = 1'b0;
        sent++;
      end
    end
    clk_n(4);
    spi_SS_n = 1'b1;
    clk_n(6);
  endtask

  typedef struct {
    bit         pre_vld;
    logic [7:0] pre;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t vecs[4];
  int   u0;

  initial begin
    // Every word consumes one load at its start and the trailing SCLK fall loads once more.
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
    vecs[1] = '{1'b0, 8'h00, 8'hF0, 8'h00, 2};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1};
    vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 1};

    reset_reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    spi_SS_n = 1'b1;
    spi_SCLK = 1'b0;
    spi_MOSI = 1'b0;
    repeat (2) begin
      @(negedge clk_clk);
      spi_SCLK = 1'($urandom_range(1));
      spi_MOSI = 1'($urandom_range(1));
      spi_SS_n = 1'($urandom_range(1));
    end
    @(negedge clk_clk);
    spi_SCLK = 1'b0;
    spi_MOSI = 1'b0;
    spi_SS_n = 1'b1;
    check("rst_miso", 32'(spi_MISO), 32'h0);
    check("rst_miso_oe", 32'(miso_oe), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_reset_n = 1'b1;
    clk_n(5);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Single-word table
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].pre_vld) push_tx(vecs[i].pre);
      u0 = und_cnt;
      mosi_w[0] = vecs[i].mosi;
      xfer(1, 0, 1'b0, 8'h00);
      check("vec_miso", 32'(miso_w[0]), 32'(vecs[i].exp_miso));
      check("vec_underruns", 32'(und_cnt - u0), 32'(vecs[i].exp_und));
      check("vec_rx_drained", 32'(rx_q.size()), 32'h0);
      check("vec_tx_ready", 32'(tx_ready), 32'h1);
      check("vec_busy_after", 32'(busy), 32'h0);
    end

    // Burst: three words under one select, second word supplied once the buffer frees up
    push_tx(8'h11);
    mosi_w[0] = 8'h01;
    mosi_w[1] = 8'h02;
    mosi_w[2] = 8'h03;
    u0 = und_cnt;
    fork
      xfer(3, 0, 1'b0, 8'h00);
      begin
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 100) begin
          @(negedge clk_clk);
          t++;
        end
        check("burst_ready_rise", 32'(tx_ready), 32'h1);
        push_tx(8'h22);
      end
    join
    check("burst_miso0", 32'(miso_w[0]), 32'h11);
    check("burst_miso1", 32'(miso_w[1]), 32'h22);
    check("burst_miso2", 32'(miso_w[2]), 32'h00);
    // Word 3 start and the trailing load both find the buffer empty.
    check("burst_underruns", 32'(und_cnt - u0), 32'h2);
    check("burst_rx_drained", 32'(rx_q.size()), 32'h0);

    // Abort after 5 bits, then a clean word must be received aligned
    mosi_w[0] = 8'hFF;
    u0 = und_cnt;
    xfer(1, 5, 1'b0, 8'h00);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_underruns", 32'(und_cnt - u0), 32'h1);
    push_tx(8'h69);
    mosi_w[0] = 8'h96;
    xfer(1, 0, 1'b0, 8'h00);
    check("abort_next_miso", 32'(miso_w[0]), 32'h69);
    check("abort_next_rx_drained", 32'(rx_q.size()), 32'h0);

    // Collision: word offered exactly in the load cycle goes out one word later
    mosi_w[0] = 8'hC3;
    mosi_w[1] = 8'h3C;
    u0 = und_cnt;
    xfer(2, 0, 1'b1, 8'h5A);
    check("coll_miso0", 32'(miso_w[0]), 32'h00);
    check("coll_miso1", 32'(miso_w[1]), 32'h5A);
    check("coll_underruns", 32'(und_cnt - u0), 32'h2);
    check("coll_rx_drained", 32'(rx_q.size()), 32'h0);

    // Idle noise: SCLK/MOSI wiggle with select high
    push_tx(8'h77);
    idle_watch = 1'b1;
    repeat (40) begin
      spi_SCLK = 1'($urandom_range(1));
      spi_MOSI = 1'($urandom_range(1));
      clk_n(1);
    end
    spi_SCLK = 1'b0;
    clk_n(4);
    idle_watch = 1'b0;
    check("noise_tx_ready", 32'(tx_ready), 32'h0);
    check("noise_busy", 32'(busy), 32'h0);
    mosi_w[0] = 8'h5C;
    u0 = und_cnt;
    xfer(1, 0, 1'b0, 8'h00);
    check("noise_next_miso", 32'(miso_w[0]), 32'h77);
    check("noise_next_underruns", 32'(und_cnt - u0), 32'h1);
    check("noise_rx_drained", 32'(rx_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
